// File: rtl/tsc_sync_ctl.sv
// tsc_sync_ctl: sequencer for the time stamp counter / phase detector.
// It qualifies the GPS 3D fix, aligns the TSC pulse counters to GPS 1PPS,
// re-arms the PFD and grades lock from the per-second phase error.
// Lock and holdover status go to the CPU registers and the OCXO steering loop.
// Optional feature: define TSC_SYNC_CTL_IRQ_EN to add the irq/irq_clr ports,
// which give a sticky interrupt on entry to or exit from LOCKED/HOLDOVER.
module tsc_sync_ctl #(
  parameter int unsigned FIX_QUAL_SEC = 8,
  parameter int unsigned LOCK_THRESH  = 100,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned UNLOCK_CNT   = 3,
  parameter int unsigned TRIG_TIMEOUT = 110000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gps_1pps_d,
  input  logic        gps_3dfix_d,
  input  logic        pll_trig,
  input  logic [31:0] pdiff_1pps,
  input  logic        sw_resync,
`ifdef TSC_SYNC_CTL_IRQ_EN
  input  logic        irq_clr,
  output logic        irq,
`endif
  output logic        tsc_sync,
  output logic        pfd_resync,
  output logic        locked,
  output logic        holdover,
  output logic [2:0]  sync_state,
  output logic [3:0]  bad_run
);

  typedef enum logic [2:0] {
    ST_NOFIX    = 3'd0,
    ST_QUAL     = 3'd1,
    ST_ALIGN    = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_HOLDOVER = 3'd5
  } state_t;

  localparam logic [7:0]  QUAL_LAST   = 8'(FIX_QUAL_SEC - 1);
  localparam logic [30:0] THRESH_W    = 31'(LOCK_THRESH);
  localparam logic [3:0]  LOCK_CNT_W  = 4'(LOCK_CNT);
  localparam logic [3:0]  UNLOCK_W    = 4'(UNLOCK_CNT);
  localparam logic [31:0] TO_MAX      = 32'(TRIG_TIMEOUT);
  localparam logic [31:0] TO_FIRE     = 32'(TRIG_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  qual_cnt_reg, qual_cnt_next;
  logic [3:0]  good_cnt_reg, good_cnt_next;
  logic [3:0]  bad_run_reg, bad_run_next;
  logic [31:0] to_cnt_reg;
  logic        trig_d_reg;
  logic        tsc_sync_reg;
  logic        pfd_resync_reg;
  logic        locked_reg;
  logic        holdover_reg;

  logic [30:0] pdiff_abs;
  logic        pdiff_good;
  logic        timeout_fire;
  logic        state_change;
  logic [3:0]  bad_inc;

  // Magnitude of the phase error; the most negative value has no positive
  // twin in 32 bits, so it is pinned to the largest magnitude (always bad).
  always_comb begin
    pdiff_abs = pdiff_1pps[30:0];
    if (pdiff_1pps[31]) begin
      if (pdiff_1pps[30:0] == 31'd0) begin
        pdiff_abs = 31'h7FFF_FFFF;
      end else begin
        pdiff_abs = ~pdiff_1pps[30:0] + 31'd1;
      end
    end
    pdiff_good = (pdiff_abs <= THRESH_W);
  end

  assign timeout_fire = (to_cnt_reg == TO_FIRE);
  assign state_change = (state_next != state_reg);
  assign bad_inc      = (bad_run_reg == 4'hF) ? 4'hF : bad_run_reg + 4'd1;

  // Next-state and counter updates; priority is fix loss, then software
  // resync, then trigger timeout, then phase grading.
  always_comb begin
    state_next    = state_reg;
    qual_cnt_next = qual_cnt_reg;
    good_cnt_next = good_cnt_reg;
    bad_run_next  = bad_run_reg;
    case (state_reg)
      ST_NOFIX: begin
        if (gps_3dfix_d) state_next = ST_QUAL;
      end
      ST_QUAL: begin
        if (!gps_3dfix_d) begin
          state_next = ST_NOFIX;
        end else if (gps_1pps_d) begin
          if (qual_cnt_reg == QUAL_LAST) state_next = ST_ALIGN;
          else qual_cnt_next = qual_cnt_reg + 8'd1;
        end
      end
      ST_ALIGN: begin
        if (!gps_3dfix_d) begin
          state_next = ST_NOFIX;
        end else if (sw_resync) begin
          state_next = ST_ALIGN;
        end else if (gps_1pps_d) begin
          state_next = ST_LOCKWAIT;
        end
      end
      ST_LOCKWAIT: begin
        if (!gps_3dfix_d) begin
          state_next = ST_NOFIX;
        end else if (sw_resync || timeout_fire) begin
          state_next = ST_ALIGN;
        end else if (trig_d_reg) begin
          if (!pdiff_good) begin
            good_cnt_next = 4'd0;
          end else if (good_cnt_reg + 4'd1 == LOCK_CNT_W) begin
            state_next = ST_LOCKED;
          end else begin
            good_cnt_next = good_cnt_reg + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (!gps_3dfix_d) begin
          state_next = ST_HOLDOVER;
        end else if (sw_resync) begin
          state_next = ST_ALIGN;
        end else if (timeout_fire) begin
          state_next = ST_HOLDOVER;
        end else if (trig_d_reg) begin
          if (pdiff_good) begin
            bad_run_next = 4'd0;
          end else if (bad_inc == UNLOCK_W) begin
            state_next = ST_ALIGN;
          end else begin
            bad_run_next = bad_inc;
          end
        end
      end
      ST_HOLDOVER: begin
        if (gps_3dfix_d) state_next = ST_QUAL;
      end
      default: begin
        state_next = ST_NOFIX;
      end
    endcase
    // Every state entry starts its run counters from zero.
    if (state_next != state_reg) begin
      good_cnt_next = 4'd0;
      bad_run_next  = 4'd0;
      if (state_next == ST_QUAL) qual_cnt_next = 8'd0;
    end
  end

  // State, counters and registered outputs; outputs track the new state so
  // they change on the same edge as sync_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_NOFIX;
      qual_cnt_reg   <= 8'd0;
      good_cnt_reg   <= 4'd0;
      bad_run_reg    <= 4'd0;
      to_cnt_reg     <= 32'd0;
      trig_d_reg     <= 1'b0;
      tsc_sync_reg   <= 1'b0;
      pfd_resync_reg <= 1'b0;
      locked_reg     <= 1'b0;
      holdover_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      qual_cnt_reg   <= qual_cnt_next;
      good_cnt_reg   <= good_cnt_next;
      bad_run_reg    <= bad_run_next;
      trig_d_reg     <= pll_trig;
      tsc_sync_reg   <= (state_next == ST_ALIGN);
      pfd_resync_reg <= (state_next == ST_LOCKWAIT) && (state_reg != ST_LOCKWAIT);
      locked_reg     <= (state_next == ST_LOCKED);
      holdover_reg   <= (state_next == ST_HOLDOVER);
      if (trig_d_reg || state_change) begin
        to_cnt_reg <= 32'd0;
      end else if (to_cnt_reg != TO_MAX) begin
        to_cnt_reg <= to_cnt_reg + 32'd1;
      end
    end
  end

`ifdef TSC_SYNC_CTL_IRQ_EN
  logic irq_reg;
  logic irq_set;

  assign irq_set = state_change &&
                   (state_reg == ST_LOCKED || state_reg == ST_HOLDOVER ||
                    state_next == ST_LOCKED || state_next == ST_HOLDOVER);

  // Sticky interrupt on lock/holdover changes; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else if (irq_set) begin
      irq_reg <= 1'b1;
    end else if (irq_clr) begin
      irq_reg <= 1'b0;
    end
  end

  assign irq = irq_reg;
`endif

  assign tsc_sync   = tsc_sync_reg;
  assign pfd_resync = pfd_resync_reg;
  assign locked     = locked_reg;
  assign holdover   = holdover_reg;
  assign sync_state = state_reg;
  assign bad_run    = bad_run_reg;

endmodule

// File: tb/tb_tsc_sync_ctl.sv
// Bench for tsc_sync_ctl: table-driven grading vectors plus hand-written
// sequences, checked through a scoreboard queue of expected outputs.
module tb_tsc_sync_ctl;

  localparam int GAP_PPS  = 1000;
  localparam int GAP_TRIG = 300;
  localparam int TO       = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gps_1pps_d;
  logic        gps_3dfix_d;
  logic        pll_trig;
  logic [31:0] pdiff_1pps;
  logic        sw_resync;
  logic        tsc_sync;
  logic        pfd_resync;
  logic        locked;
  logic        holdover;
  logic [2:0]  sync_state;
  logic [3:0]  bad_run;
`ifdef TSC_SYNC_CTL_IRQ_EN
  logic        irq;
  logic        irq_clr;
`endif

  always #5 clk = ~clk;

  tsc_sync_ctl #(.TRIG_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gps_1pps_d  (gps_1pps_d),
    .gps_3dfix_d (gps_3dfix_d),
    .pll_trig    (pll_trig),
    .pdiff_1pps  (pdiff_1pps),
    .sw_resync   (sw_resync),
`ifdef TSC_SYNC_CTL_IRQ_EN
    .irq_clr     (irq_clr),
    .irq         (irq),
`endif
    .tsc_sync    (tsc_sync),
    .pfd_resync  (pfd_resync),
    .locked      (locked),
    .holdover    (holdover),
    .sync_state  (sync_state),
    .bad_run     (bad_run)
  );

  typedef struct {
    logic [2:0] st;
    logic [3:0] bad;
    logic       tsc;
    logic       pfd;
  } exp_t;

  typedef struct {
    logic [31:0] pdiff;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] bad,
                              input logic tsc, input logic pfd);
    exp_t e;
    e.st  = st;
    e.bad = bad;
    e.tsc = tsc;
    e.pfd = pfd;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_pop(input string name);
    exp_t       e;
    logic [9:0] act;
    logic [9:0] req;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, state=%0d", name, sync_state);
      return;
    end
    e   = sb_q.pop_front();
    act = {sync_state, bad_run, tsc_sync, pfd_resync, locked, holdover};
    req = {e.st, e.bad, e.tsc, e.pfd, (e.st == 3'd4), (e.st == 3'd5)};
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got state=%0d bad_run=%0d tsc=%b pfd=%b locked=%b holdover=%b, need state=%0d bad_run=%0d tsc=%b pfd=%b locked=%b holdover=%b",
               name, sync_state, bad_run, tsc_sync, pfd_resync, locked, holdover,
               e.st, e.bad, e.tsc, e.pfd, (e.st == 3'd4), (e.st == 3'd5));
    end else begin
      $display("[TB] ok %s state=%0d bad_run=%0d", name, sync_state, bad_run);
    end
  endtask

  task automatic pps(input exp_t e, input string name);
    idle(GAP_PPS);
    gps_1pps_d = 1'b1;
    sb_q.push_back(e);
    tick();
    gps_1pps_d = 1'b0;
    check_pop(name);
  endtask

  task automatic trig(input logic [31:0] pd, input exp_t e, input string name);
    idle(GAP_TRIG);
    pll_trig = 1'b1;
    tick();
    pll_trig   = 1'b0;
    pdiff_1pps = pd;
    sb_q.push_back(e);
    tick();
    check_pop(name);
  endtask

  task automatic resync(input exp_t e, input string name);
    sw_resync = 1'b1;
    sb_q.push_back(e);
    tick();
    sw_resync = 1'b0;
    check_pop(name);
  endtask

  // From ALIGN: one GPS pulse into LOCKWAIT, then four good trigs to LOCKED.
  task automatic relock(input string name);
    pps(mk(3'd3, 4'd0, 1'b0, 1'b1), {name, "_lw"});
    for (int i = 0; i < 3; i++) trig(32'd0, mk(3'd3, 4'd0, 1'b0, 1'b0), {name, "_good"});
    trig(32'd0, mk(3'd4, 4'd0, 1'b0, 1'b0), {name, "_lock"});
  endtask

  task automatic qualify(input string name);
    for (int i = 0; i < 7; i++) pps(mk(3'd1, 4'd0, 1'b0, 1'b0), {name, "_qual"});
    pps(mk(3'd2, 4'd0, 1'b1, 1'b0), {name, "_align"});
  endtask

`ifdef TSC_SYNC_CTL_IRQ_EN
  task automatic check_irq(input logic req, input string name);
    n_tests++;
    if (irq !== req) begin
      n_fail++;
      $display("FAIL %s: irq=%b need %b", name, irq, req);
    end else begin
      $display("[TB] ok %s irq=%b", name, irq);
    end
  endtask
`endif

  vec_t lw_tab[7];
  vec_t lk_tab[7];

  initial begin
    // LOCKWAIT grading: a -101 error restarts the good count.
    lw_tab[0] = '{32'd50,         mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[1] = '{-32'sd100,      mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[2] = '{-32'sd101,      mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[3] = '{32'd50,         mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[4] = '{-32'sd100,      mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[5] = '{32'd3,          mk(3'd3, 4'd0, 1'b0, 1'b0)};
    lw_tab[6] = '{32'd0,          mk(3'd4, 4'd0, 1'b0, 1'b0)};
    // LOCKED grading: good trigs reset bad_run, third consecutive bad -> ALIGN.
    lk_tab[0] = '{32'd500,        mk(3'd4, 4'd1, 1'b0, 1'b0)};
    lk_tab[1] = '{32'd100,        mk(3'd4, 4'd0, 1'b0, 1'b0)};
    lk_tab[2] = '{32'd101,        mk(3'd4, 4'd1, 1'b0, 1'b0)};
    lk_tab[3] = '{-32'sd100,      mk(3'd4, 4'd0, 1'b0, 1'b0)};
    lk_tab[4] = '{32'd500,        mk(3'd4, 4'd1, 1'b0, 1'b0)};
    lk_tab[5] = '{32'h8000_0000,  mk(3'd4, 4'd2, 1'b0, 1'b0)};
    lk_tab[6] = '{32'd500,        mk(3'd2, 4'd0, 1'b1, 1'b0)};

    rst_n       = 1'b0;
    gps_1pps_d  = 1'b1;
    gps_3dfix_d = 1'b1;
    pll_trig    = 1'b0;
    pdiff_1pps  = 32'd0;
    sw_resync   = 1'b0;
`ifdef TSC_SYNC_CTL_IRQ_EN
    irq_clr     = 1'b0;
`endif

    // Reset holds everything at NOFIX even with fix and pulses present.
    sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0));
    idle(3);
    check_pop("reset");
`ifdef TSC_SYNC_CTL_IRQ_EN
    check_irq(1'b0, "reset_irq");
`endif
    gps_1pps_d  = 1'b0;
    gps_3dfix_d = 1'b0;
    rst_n       = 1'b1;
    sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0));
    idle(5);
    check_pop("nofix_idle");

    gps_3dfix_d = 1'b1;
    sb_q.push_back(mk(3'd1, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("fix_to_qual");

    qualify("q1");
    resync(mk(3'd2, 4'd0, 1'b1, 1'b0), "resync_in_align");

    // 9th pulse: tsc_sync falls, pfd_resync pulses exactly one clock.
    pps(mk(3'd3, 4'd0, 1'b0, 1'b1), "align_to_lw");
    sb_q.push_back(mk(3'd3, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("pfd_pulse_end");

    for (int i = 0; i < 7; i++) trig(lw_tab[i].pdiff, lw_tab[i].exp, $sformatf("lw_vec%0d", i));
    for (int i = 0; i < 7; i++) trig(lk_tab[i].pdiff, lk_tab[i].exp, $sformatf("lk_vec%0d", i));

    // Software resync drops lock.
    relock("r1");
`ifdef TSC_SYNC_CTL_IRQ_EN
    check_irq(1'b1, "irq_on_lock");
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_irq(1'b0, "irq_cleared");
`endif
    resync(mk(3'd2, 4'd0, 1'b1, 1'b0), "resync_in_locked");
`ifdef TSC_SYNC_CTL_IRQ_EN
    check_irq(1'b1, "irq_on_unlock");
`endif

    // Fix loss while LOCKED -> HOLDOVER; resync and trigs there are ignored.
    relock("r2");
    gps_3dfix_d = 1'b0;
    sb_q.push_back(mk(3'd5, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("fixloss_holdover");
    resync(mk(3'd5, 4'd0, 1'b0, 1'b0), "resync_in_holdover");
    trig(32'd500, mk(3'd5, 4'd0, 1'b0, 1'b0), "trig_in_holdover");
    gps_3dfix_d = 1'b1;
    sb_q.push_back(mk(3'd1, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("holdover_to_qual");
    qualify("q2");

    // Trigger timeout in LOCKED: fires exactly TO clocks after entry.
    relock("r3");
    sb_q.push_back(mk(3'd4, 4'd0, 1'b0, 1'b0));
    idle(TO - 1);
    check_pop("locked_before_to");
    sb_q.push_back(mk(3'd5, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("locked_timeout");
    sb_q.push_back(mk(3'd1, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("to_holdover_fix_qual");
    qualify("q3");

    // Trigger timeout in LOCKWAIT returns to ALIGN.
    pps(mk(3'd3, 4'd0, 1'b0, 1'b1), "lw_for_to");
    sb_q.push_back(mk(3'd3, 4'd0, 1'b0, 1'b0));
    idle(TO - 1);
    check_pop("lw_before_to");
    sb_q.push_back(mk(3'd2, 4'd0, 1'b1, 1'b0));
    tick();
    check_pop("lw_timeout");

    // Fix loss beats a simultaneous GPS pulse in ALIGN.
    gps_3dfix_d = 1'b0;
    gps_1pps_d  = 1'b1;
    sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0));
    tick();
    gps_1pps_d = 1'b0;
    check_pop("align_fixloss_pps");

    // Fix loss during QUAL.
    gps_3dfix_d = 1'b1;
    sb_q.push_back(mk(3'd1, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("requal");
    gps_3dfix_d = 1'b0;
    sb_q.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0));
    tick();
    check_pop("qual_fixloss");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
